// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer sharing one single-port memory between fetch (if) and load/store (ls).
// Optional anti-starvation guard for the fetch port: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_wstrb,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (DATA_W != 32 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("mem_arbiter: DATA_W must be 32 and STARVE_LIMIT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner_ls;
    logic   starve_fire;
    logic   ls_win;
    logic   if_win;

    // Fetch wins when it is alone, or when the guard forces it past a waiting ls.
    assign ls_win = ls_req && !starve_fire;
    assign if_win = if_req && !ls_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve_fire = (starve_cnt == CNT_W'(STARVE_LIMIT)) && if_req && ls_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (if_win || !if_req) begin
                starve_cnt <= '0;
            end else if (ls_win) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign starve_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        case (state)
            IDLE: begin
                if_gnt = if_win;
                ls_gnt = ls_win;
                if (if_win || ls_win) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_nxt = mem_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req = (state == REQ);
    assign busy    = (state != IDLE);

    // Command capture at grant, response routing back to the owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_ls  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_win || if_win) begin
                        owner_ls  <= ls_win;
                        mem_we    <= ls_win && ls_we;
                        mem_addr  <= ls_win ? ls_addr : if_addr;
                        mem_wdata <= ls_win ? ls_wdata : '0;
                        mem_wstrb <= ls_win ? ls_wstrb : 4'b0000;
                    end
                end
                REQ: begin
                    if (mem_ready && mem_we) begin
                        ls_rvalid <= 1'b1;
                        ls_rdata  <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_ls) begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
